// File: rtl/ram_dual_port_be.sv
// ram_dual_port_be: single-clock RAM with one write port and one read port,
// per-byte write enables, a registered read with valid strobe, and a
// post-reset sweep that clears the array to zero.
// Optional build macro RAM_PARITY_EN adds one even-parity bit per byte and
// reports mismatches on rd_err. Without it, rd_err is tied to 0.
module ram_dual_port_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done,
    output logic                    rd_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_ptr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [NB-1:0]           mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rd_fire;

    // Clear sweep state and pointer; reset always restarts the full sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Leave CLEAR after the last address has been written.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == ADDR_WIDTH'(DEPTH - 1))
            state_nxt = RUN;
    end

    assign init_done = (state == RUN);
    assign rd_fire   = (state == RUN) && rd_en;

    // Array write port: the clear sweep owns it in CLEAR, the user in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_be    = wr_be;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr;
            mem_be    = '1;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_en;
        end
    end

    // Byte-lane array write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++)
                if (mem_be[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Read word: old contents, or write-first lane merge on a same-address collision.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == 1 && wr_en && wr_addr == rd_addr) begin
            for (int i = 0; i < NB; i++)
                if (wr_be[i])
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Registered read data and one-cycle valid strobe; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire)
                rd_data <= rd_word;
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] rd_par;
    logic          par_bad;

    // Parity array: even parity per written byte; disabled lanes keep theirs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++)
                if (mem_be[i])
                    mem_par[mem_addr][i] <= ^mem_wdata[8*i +: 8];
        end
    end

    // Stored parity for the read word, with fresh parity on merged lanes.
    always_comb begin
        rd_par  = mem_par[rd_addr];
        par_bad = 1'b0;
        if (RDW_MODE == 1 && wr_en && wr_addr == rd_addr) begin
            for (int i = 0; i < NB; i++)
                if (wr_be[i])
                    rd_par[i] = ^wr_data[8*i +: 8];
        end
        for (int i = 0; i < NB; i++)
            if ((^rd_word[8*i +: 8]) != rd_par[i])
                par_bad = 1'b1;
    end

    // Error flag refreshed on every read, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_err <= 1'b0;
        else if (rd_fire)
            rd_err <= par_bad;
    end
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dual_port_be.sv
// Bench for ram_dual_port_be: one read-first and one write-first instance
// share stimulus; expected read data is queued at issue and popped when
// rd_valid appears. Define RAM_PARITY_EN to also exercise parity errors.
module tb_ram_dual_port_be;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, init_done0, init_done1, rd_err0, rd_err1;

    int tests = 0;
    int fails = 0;
    int clr_cnt = 0;
    logic exp_err = 1'b0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    ram_dual_port_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .init_done(init_done0), .rd_err(rd_err0));

    ram_dual_port_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .init_done(init_done1), .rd_err(rd_err1));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expectations pushed at issue, checked after the edge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [3:0] ra,
                        input logic [31:0] e0, input logic [31:0] e1);
        logic running;
        logic pushed;
        running = (clr_cnt == 16);
        pushed  = re && running;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (pushed) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clk);
        if (!running) clr_cnt++;
        #1;
        chk("rd_valid0", 32'(rd_valid0), 32'(pushed));
        chk("rd_valid1", 32'(rd_valid1), 32'(pushed));
        chk("init_done", 32'({init_done1, init_done0}), (clr_cnt == 16) ? 32'd3 : 32'd0);
        if (rd_valid0 && q0.size() > 0) chk("rd_data0", rd_data0, q0.pop_front());
        if (rd_valid1 && q1.size() > 0) chk("rd_data1", rd_data1, q1.pop_front());
        if (pushed) chk("rd_err", 32'({rd_err1, rd_err0}), exp_err ? 32'd3 : 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst rd_data0", rd_data0, 32'd0);
        chk("rst rd_data1", rd_data1, 32'd0);
        chk("rst valid/init/err", 32'({rd_valid0, rd_valid1, init_done0, init_done1, rd_err0, rd_err1}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_cnt = 0;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 4'd3,  4'hF, 32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        32'h0};
        vt[1]  = '{1'b1, 4'd3,  4'h5, 32'h11223344, 1'b0, 4'd0,  32'h0,        32'h0};
        vt[2]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  32'hDE22BE44, 32'hDE22BE44};
        vt[3]  = '{1'b1, 4'd5,  4'hF, 32'hAAAAAAAA, 1'b0, 4'd0,  32'h0,        32'h0};
        vt[4]  = '{1'b1, 4'd5,  4'hF, 32'h55555555, 1'b1, 4'd5,  32'hAAAAAAAA, 32'h55555555};
        vt[5]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h55555555, 32'h55555555};
        vt[6]  = '{1'b1, 4'd6,  4'h0, 32'hFFFFFFFF, 1'b1, 4'd6,  32'h0,        32'h0};
        vt[7]  = '{1'b1, 4'd9,  4'h8, 32'hCAFEF00D, 1'b1, 4'd3,  32'hDE22BE44, 32'hDE22BE44};
        vt[8]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd9,  32'hCA000000, 32'hCA000000};
        vt[9]  = '{1'b1, 4'd9,  4'h1, 32'h12345678, 1'b1, 4'd9,  32'hCA000000, 32'hCA000078};
        vt[10] = '{1'b1, 4'd15, 4'hF, 32'hFFFFFFFF, 1'b1, 4'd0,  32'h0,        32'h0};
        vt[11] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF};

        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        rst_n = 1'b0;
        #12;
        do_reset();

        // Clear sweep with a write and read attempted on cycle 4; both must be ignored.
        idle(3);
        step(1'b1, 4'd8, 4'hF, 32'h12345678, 1'b1, 4'd8, 32'h0, 32'h0);
        idle(12);

        // Every address reads zero after the sweep.
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a), 32'd0, 32'd0);

        // Table-driven writes, partial writes, RDW collisions and reads.
        for (int i = 0; i < 12; i++)
            step(vt[i].we, vt[i].wa, vt[i].be, vt[i].wd, vt[i].re, vt[i].ra, vt[i].e0, vt[i].e1);

        // Idle read port holds the last word with valid low.
        idle(1);
        chk("hold rd_data0", rd_data0, 32'hFFFFFFFF);
        chk("hold rd_data1", rd_data1, 32'hFFFFFFFF);

        // Reset mid-RUN restarts the sweep and wipes earlier writes.
        step(1'b1, 4'd7, 4'hF, 32'h12345678, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h12345678, 32'h12345678);
        do_reset();
        idle(16);
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7, 32'd0, 32'd0);

`ifdef RAM_PARITY_EN
        // A flipped stored bit raises rd_err; a clean read clears it.
        step(1'b1, 4'd2, 4'hF, 32'h0F0F0F0F, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b1, 4'd4, 4'hF, 32'h01010101, 1'b0, 4'd0, 32'd0, 32'd0);
        dut0.mem[2][0] = ~dut0.mem[2][0];
        dut1.mem[2][0] = ~dut1.mem[2][0];
        exp_err = 1'b1;
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h0F0F0F0E, 32'h0F0F0F0E);
        exp_err = 1'b0;
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h01010101, 32'h01010101);
`endif

        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_dual_port_be.md
Name: ram_dual_port_be

Overview:
Parametrised successor to the team's single-port RAM. It has one write port and one read port on a single clock, per-byte write enables and a registered read with a valid strobe. After reset a sequencer clears the whole array to zero, so contents are known. It is the general-purpose on-chip buffer for FIFOs, frame stores and lookup tables in the design.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (old data), 1 = write-first (merged new data)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_be  input  NB  byte enables; bit i writes wr_data[8i+7:8i]
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle strobe; rd_data is valid
init_done  output  1  high once the post-reset clear completes
rd_err  output  1  parity error on the current rd_data (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously forces rd_data=0, rd_valid=0, init_done=0, rd_err=0, clear pointer=0, FSM=CLEAR. The array itself has no reset; it is cleared by the FSM.
- FSM states:
  - CLEAR: every cycle write 0 (and matching parity) to mem[clr_ptr], then increment clr_ptr. After writing DEPTH-1, go to RUN on the next edge and set init_done=1.
  - Clear duration: exactly DEPTH cycles after rst_n deasserts.
  - RUN: normal operation; stays in RUN until reset.
- During CLEAR: wr_en and rd_en are ignored, no user write occurs, rd_valid stays 0.
- Reset asserted mid-CLEAR or mid-RUN: FSM returns to CLEAR with clr_ptr=0 and the full sweep restarts.
- Write: in RUN, wr_en=1 at edge N updates only the lanes with wr_be[i]=1. wr_be=0 with wr_en=1 is a legal no-op.
- Read latency is 1: rd_en=1 sampled at edge N gives rd_data and rd_valid=1 after edge N. rd_valid drops after edge N+1 unless rd_en is held. Back-to-back reads give one word per cycle.
- rd_en=0: rd_data holds its last value; rd_valid=0.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: rd_data is the pre-write word.
  - RDW_MODE=1: rd_data has enabled lanes from wr_data and disabled lanes from the old word.
- Read and write at different addresses: independent, no interaction.
- Addresses: full range 0..DEPTH-1; no wrap logic because the address width equals the array size.
- Widths: no arithmetic beyond the ADDR_WIDTH-bit clr_ptr. clr_ptr wraps naturally but is only used in CLEAR.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Array stores DATA_WIDTH+NB bits: one even-parity bit per byte, computed at write time over the written byte. Disabled lanes keep their old parity.
  - On read, parity is recomputed. rd_err=1 in the same cycle as rd_valid if any lane mismatches. rd_err is cleared on the next read with no error, or by reset.
  - The clear sweep writes correct parity (0) for zero data.
- Undefined: no parity storage; rd_err tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset release, DEPTH=16: init_done rises exactly 16 cycles after rst_n goes high. Read every address -> rd_data=0x00000000, rd_valid=1 one cycle after each rd_en.
- Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_be=4'b0101 with 0x11223344 -> read addr 3 gives 0xDE22BE44.
- Read and write addr 5 on the same edge, with old=0xAAAAAAAA, new=0x55555555 -> RDW_MODE=0 returns 0xAAAAAAAA; RDW_MODE=1 returns 0x55555555.
- rd_en and wr_en asserted during CLEAR (cycle 4) -> no rd_valid and no write. After init_done, the target address reads 0.
- Write 0x12345678 to addr 7, pulse rst_n low mid-RUN -> after the new clear, addr 7 reads 0 and rd_data=0 during reset.
- RAM_PARITY_EN: force-flip one stored data bit at addr 2 via hierarchical deposit -> read gives rd_err=1 with rd_valid. A following read of addr 4 gives rd_err=0.
